// File: rtl/sys_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sys_defs
// Brief    : Shared pipeline definitions: NOOP encoding and fetch queue entry.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

package sys_defs;

   localparam logic [31:0] c_noop_inst = `NOOP_INST;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        filled;
   } ifq_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : if_fetch_queue
// Brief    : Instruction prefetch queue between imem port and IF stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

module if_fetch_queue
   import sys_defs::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_npc,
   output logic [31:0] out_ir
);

   localparam int                 c_idx_w = $clog2(DEPTH);
   localparam int                 c_ptr_w = c_idx_w + 1;
   localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);

   ifq_entry_t         r_ring [DEPTH];
   logic [31:0]        r_fetch_pc;
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_fill;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_ptr_w-1:0] r_pending;
   logic [c_ptr_w-1:0] r_discard;

   logic [c_ptr_w-1:0] w_count;
   logic [c_ptr_w-1:0] w_pending_nxt;
   logic               w_req;
   logic               w_issue;
   logic               w_rsp;
   logic               w_drop;
   logic               w_fill;
   logic               w_out_valid;
   logic               w_pop;
   ifq_entry_t         w_head_entry;
   logic               w_unused_bits;

   assign w_unused_bits = ^redirect_pc[1:0];

   assign w_count      = r_tail - r_head;
   assign w_req        = !rst && !redirect_valid && (w_count < c_depth) && (r_pending < c_depth);
   assign w_issue      = w_req && imem_gnt;
   // Responses with nothing outstanding are protocol errors and are ignored.
   assign w_rsp        = imem_rsp_valid && (r_pending != '0);
   assign w_drop       = w_rsp && (r_discard != '0);
   assign w_fill       = w_rsp && (r_discard == '0);
   assign w_head_entry = r_ring[r_head[c_idx_w-1:0]];
   assign w_out_valid  = w_head_entry.filled && (r_tail != r_head) && !redirect_valid;
   assign w_pop        = w_out_valid && out_ready;

   assign w_pending_nxt = r_pending + (w_issue ? c_one : '0) - (w_rsp ? c_one : '0);

   assign imem_req  = w_req;
   assign imem_addr = r_fetch_pc;
   assign out_valid = w_out_valid;
   assign out_pc    = w_out_valid ? w_head_entry.pc : 32'h0;
   assign out_npc   = w_out_valid ? (w_head_entry.pc + 32'd4) : 32'h0;
   assign out_ir    = w_out_valid ? w_head_entry.ir : `NOOP_INST;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_head     <= '0;
         r_fill     <= '0;
         r_tail     <= '0;
         r_pending  <= '0;
         r_discard  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ring[i] <= '0;
         end
      end else if (redirect_valid) begin
         // Everything still outstanding after this cycle's response must be dropped.
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_head     <= '0;
         r_fill     <= '0;
         r_tail     <= '0;
         r_pending  <= w_pending_nxt;
         r_discard  <= w_pending_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            r_ring[i].filled <= 1'b0;
         end
      end else begin
         if (w_issue) begin
            r_ring[r_tail[c_idx_w-1:0]].pc     <= r_fetch_pc;
            r_ring[r_tail[c_idx_w-1:0]].filled <= 1'b0;
            r_tail                             <= r_tail + c_one;
            r_fetch_pc                         <= r_fetch_pc + 32'd4;
         end
         if (w_fill) begin
            r_ring[r_fill[c_idx_w-1:0]].ir     <= imem_rsp_data;
            r_ring[r_fill[c_idx_w-1:0]].filled <= 1'b1;
            r_fill                             <= r_fill + c_one;
         end
         if (w_drop) begin
            r_discard <= r_discard - c_one;
         end
         if (w_pop) begin
            r_head <= r_head + c_one;
         end
         r_pending <= w_pending_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_if_fetch_queue
// Brief    : Directed self-checking bench for if_fetch_queue with a latency-programmable imem model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_npc;
   logic [31:0] out_ir;

   int n_vec = 0;
   int n_err = 0;
   int mem_lat = 1;
   int nreq;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t mq[$];

   if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_npc        (out_npc),
      .out_ir         (out_ir)
   );

   always #5 clk = ~clk;

   // Memory model: word returned for address A is {16'hC0DE, A[15:0]}.
   initial begin
      int mcnt = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         mcnt++;
         if (mq.size() > 0 && mq[0].due == mcnt) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {16'hC0DE, mq[0].addr[15:0]};
            void'(mq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
         if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
            mq.push_back('{imem_addr, mcnt + mem_lat});
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_gnt       = 1'b1;
      out_ready      = 1'b1;
      mem_lat        = lat;
      repeat (4) go();
      rst = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state while rst is held high
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b1; out_ready = 1'b1;
      go(); go(); #1;
      chk("rst_req",   imem_req,  32'd0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", out_valid, 32'd0);
      chk("rst_pc",    out_pc,    32'h0);
      chk("rst_npc",   out_npc,   32'h0);
      chk("rst_ir",    out_ir,    32'h0000_0013);

      // Streaming, single-cycle memory
      do_reset(1);
      #1; chk("s_t0_req", imem_req, 32'd1); chk("s_t0_addr", imem_addr, 32'h0); chk("s_t0_valid", out_valid, 32'd0);
      go(); #1; chk("s_t1_addr", imem_addr, 32'h4); chk("s_t1_valid", out_valid, 32'd0);
      go(); #1; chk("s_t2_valid", out_valid, 32'd1); chk("s_t2_pc", out_pc, 32'h0);
      chk("s_t2_npc", out_npc, 32'h4); chk("s_t2_ir", out_ir, 32'hC0DE_0000);
      go(); #1; chk("s_t3_pc", out_pc, 32'h4); chk("s_t3_npc", out_npc, 32'h8);
      chk("s_t3_ir", out_ir, 32'hC0DE_0004); chk("s_t3_addr", imem_addr, 32'hC);

      // Stall until full, then release
      do_reset(1);
      out_ready = 1'b0;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) go();
         #1;
         if (imem_req === 1'b1) nreq++;
         if (i == 5) begin
            chk("stall_pc", out_pc, 32'h0);
            chk("stall_ir", out_ir, 32'hC0DE_0000);
         end
      end
      chk("full_nreq", nreq, 32'd4);
      chk("full_req",  imem_req, 32'd0);
      go(); out_ready = 1'b1; #1;
      chk("rel_valid", out_valid, 32'd1); chk("rel_pc", out_pc, 32'h0); chk("rel_req", imem_req, 32'd0);
      go(); #1;
      chk("rel_req_next", imem_req, 32'd1); chk("rel_addr_next", imem_addr, 32'h10); chk("rel_pc_next", out_pc, 32'h4);

      // Redirect with three requests in flight, 3-cycle memory
      do_reset(3);
      go(); go(); go();
      redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
      chk("r3_valid", out_valid, 32'd0); chk("r3_req", imem_req, 32'd0);
      go(); redirect_valid = 1'b0; #1;
      chk("r3_req_r1", imem_req, 32'd1); chk("r3_addr_r1", imem_addr, 32'h100);
      go(); #1; chk("r3_addr_r2", imem_addr, 32'h104); chk("r3_valid_r2", out_valid, 32'd0);
      go(); go(); #1; chk("r3_valid_r4", out_valid, 32'd0);
      go(); #1;
      chk("r3_valid_r5", out_valid, 32'd1); chk("r3_pc", out_pc, 32'h100);
      chk("r3_npc", out_npc, 32'h104); chk("r3_ir", out_ir, 32'hC0DE_0100);
      go(); #1; chk("r3_pc2", out_pc, 32'h104); chk("r3_ir2", out_ir, 32'hC0DE_0104);

      // Redirect, response and pop request in the same cycle
      do_reset(1);
      go(); go();
      redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      chk("rr_valid", out_valid, 32'd0); chk("rr_req", imem_req, 32'd0);
      go(); redirect_valid = 1'b0; #1;
      chk("rr_req_r1", imem_req, 32'd1); chk("rr_addr_r1", imem_addr, 32'h200); chk("rr_valid_r1", out_valid, 32'd0);
      go(); #1; chk("rr_valid_r2", out_valid, 32'd0);
      go(); #1;
      chk("rr_valid_r3", out_valid, 32'd1); chk("rr_pc", out_pc, 32'h200); chk("rr_ir", out_ir, 32'hC0DE_0200);

      // Grant held low for five cycles
      do_reset(1);
      imem_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) go();
         #1;
         if (i == 0 || i == 4) begin
            chk("ng_req",   imem_req,  32'd1);
            chk("ng_addr",  imem_addr, 32'h0);
            chk("ng_valid", out_valid, 32'd0);
         end
      end
      go(); imem_gnt = 1'b1; #1; chk("ng_addr_g", imem_addr, 32'h0);
      go(); #1; chk("ng_addr_g1", imem_addr, 32'h4);
      go(); #1; chk("ng_valid_g2", out_valid, 32'd1); chk("ng_pc_g2", out_pc, 32'h0);

      // Reset mid-operation with entries queued and one response in flight
      do_reset(3);
      out_ready = 1'b0;
      go();
      go(); imem_gnt = 1'b0;
      go(); imem_gnt = 1'b1; #1; chk("mr_addr_t3", imem_addr, 32'h8);
      go(); imem_gnt = 1'b0; #1;
      chk("mr_valid_t4", out_valid, 32'd1); chk("mr_pc_t4", out_pc, 32'h0);
      go(); rst = 1'b1; #1; chk("mr_req_rst", imem_req, 32'd0);
      go(); rst = 1'b0; #1;
      chk("mr_valid_after", out_valid, 32'd0); chk("mr_addr_after", imem_addr, 32'h0);
      chk("mr_req_after", imem_req, 32'd1); chk("mr_pc_after", out_pc, 32'h0);
      go(); imem_gnt = 1'b1; #1; chk("mr_req_late", imem_req, 32'd1);
      go(); go(); go(); go(); #1;
      chk("mr_valid_new", out_valid, 32'd1); chk("mr_pc_new", out_pc, 32'h0); chk("mr_ir_new", out_ir, 32'hC0DE_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
